// File: rtl/led_line_shifter_if.sv
// Scan-line request, framebuffer read port and panel data lines of the LED line shifter.
`timescale 1ns/1ps
interface led_line_shifter_if #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5
);
    localparam int ADDR_BITS = ROW_BITS + $clog2(COLS);

    logic                 line_begin;
    logic [ROW_BITS-1:0]  line_addr;
    logic [3:0]           line_pwm;
    logic                 line_done;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_rd_en;
    logic [23:0]          ram_rdata;
    logic                 sclk;
    logic                 r0, g0, b0, r1, g1, b1;

    modport slave (
        input  line_begin, line_addr, line_pwm, ram_rdata,
        output line_done, ram_addr, ram_rd_en, sclk, r0, g0, b0, r1, g1, b1
    );

    modport master (
        output line_begin, line_addr, line_pwm, ram_rdata,
        input  line_done, ram_addr, ram_rd_en, sclk, r0, g0, b0, r1, g1, b1
    );
endinterface

// File: rtl/led_line_shifter.sv
// Shifts one framebuffer row into a HUB75-style panel, one bit-plane per line request.
`timescale 1ns/1ps
module led_line_shifter #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5
) (
    input logic               clk_25MHz,
    input logic               rst_n,
    led_line_shifter_if.slave bus
);
    localparam int COL_BITS = $clog2(COLS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);

    logic [1:0]          state;
    logic [COL_BITS-1:0] col;
    logic [COL_BITS-1:0] col_nxt;
    logic [ROW_BITS-1:0] row;
    logic [1:0]          plane;

    assign col_nxt = col + COL_BITS'(1);

    function automatic logic pick(input logic [3:0] field, input logic [1:0] sel);
        return field[sel];
    endfunction

    // LOAD consumes the word addressed one cycle earlier; HIGH issues the next read.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            plane         <= '0;
            bus.sclk      <= 1'b0;
            bus.line_done <= 1'b0;
            bus.ram_rd_en <= 1'b0;
            bus.ram_addr  <= '0;
            bus.r0        <= 1'b0;
            bus.g0        <= 1'b0;
            bus.b0        <= 1'b0;
            bus.r1        <= 1'b0;
            bus.g1        <= 1'b0;
            bus.b1        <= 1'b0;
        end else begin
            bus.line_done <= 1'b0;
            bus.ram_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.line_begin) begin
                        row           <= bus.line_addr;
                        plane         <= bus.line_pwm[1:0];
                        col           <= '0;
                        bus.ram_addr  <= {bus.line_addr, {COL_BITS{1'b0}}};
                        bus.ram_rd_en <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    bus.r0   <= pick(bus.ram_rdata[3:0],   plane);
                    bus.g0   <= pick(bus.ram_rdata[7:4],   plane);
                    bus.b0   <= pick(bus.ram_rdata[11:8],  plane);
                    bus.r1   <= pick(bus.ram_rdata[15:12], plane);
                    bus.g1   <= pick(bus.ram_rdata[19:16], plane);
                    bus.b1   <= pick(bus.ram_rdata[23:20], plane);
                    bus.sclk <= 1'b0;
                    state    <= HIGH;
                end
                HIGH: begin
                    bus.sclk <= 1'b1;
                    if (col != LAST_COL) begin
                        col           <= col_nxt;
                        bus.ram_addr  <= {row, col_nxt};
                        bus.ram_rd_en <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.sclk      <= 1'b0;
                    bus.line_done <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/led_line_shifter.md
LED_LINE_SHIFTER -- requirements
Module: led_line_shifter

Interface
REQ-001 Parameter COLS, default 64: panel columns per scan line; SHALL be a power of two from 2 to 64.
REQ-002 Parameter ROW_BITS, default 5: width of the row address.
REQ-003 Port clk_25MHz, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port line_begin, input, 1: one-cycle request to shift one scan line.
REQ-006 Port line_addr, input, ROW_BITS: row to shift.
REQ-007 Port line_pwm, input, 4: bit-plane select; only [1:0] used, [3:2] ignored.
REQ-008 Port line_done, output, 1: one-cycle pulse when the line is fully shifted.
REQ-009 Port ram_addr, output, ROW_BITS+log2(COLS): framebuffer read address {row, col}.
REQ-010 Port ram_rd_en, output, 1: framebuffer read strobe.
REQ-011 Port ram_rdata, input, 24: read data, valid one cycle after ram_rd_en is sampled high.
REQ-012 Port ram_rdata fields: [3:0] R upper, [7:4] G upper, [11:8] B upper, [15:12] R lower, [19:16] G lower, [23:20] B lower.
REQ-013 Port sclk, output, 1: panel shift clock; the panel samples data on the sclk rising edge.
REQ-014 Ports r0, g0, b0, r1, g1, b1, outputs, 1 each: panel data for the upper and lower half.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FSM states: IDLE, LOAD, HIGH, DONE.
REQ-017 IDLE behaviour:
- line_begin=1 SHALL capture row=line_addr, plane=line_pwm[1:0], col=0.
- It SHALL drive ram_addr={line_addr,0} and ram_rd_en=1, then go to LOAD.
REQ-018 LOAD behaviour:
- Colour outputs SHALL take the plane bit of each field: r0=ram_rdata[plane], g0=ram_rdata[4+plane], b0=ram_rdata[8+plane], r1=ram_rdata[12+plane], g1=ram_rdata[16+plane], b1=ram_rdata[20+plane].
- It SHALL drive sclk=0 and ram_rd_en=0, then go to HIGH.
REQ-019 HIGH behaviour:
- It SHALL drive sclk=1.
- If col<COLS-1: col increments, ram_addr={row,col+1}, ram_rd_en=1, next state LOAD.
- Otherwise: next state DONE.
REQ-020 DONE SHALL drive sclk=0 and line_done=1 for exactly one cycle, then return to IDLE with line_done=0.
REQ-021 Timing from line_begin sampled at edge E0:
- Column k data SHALL change at edge E(2k+1).
- sclk SHALL rise at edge E(2k+2).
- line_done SHALL be high from E(2*COLS+1) to E(2*COLS+2).
- A line is 2*COLS+2 cycles (130 for COLS=64).
REQ-022 Colour outputs SHALL hold stable whenever sclk is high.
REQ-023 line_begin outside IDLE SHALL be ignored; captured row and plane SHALL not change mid-line.
REQ-024 line_begin sampled in the same cycle DONE returns to IDLE SHALL be ignored; a new request is accepted from the first IDLE cycle onward.
REQ-025 col SHALL never exceed COLS-1 and SHALL not wrap within a line.
REQ-026 Exactly COLS sclk rising edges and exactly one line_done pulse SHALL occur per accepted line_begin.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, col=0, row=0, plane=0, sclk=0, line_done=0, ram_rd_en=0, ram_addr=0 and all colour outputs 0.
REQ-028 Reset mid-line SHALL abort the line without a line_done pulse; after release the block SHALL wait for a new line_begin.

Verification
REQ-029 line_begin with line_addr=5, line_pwm=0 and RAM word for col c = c[0] ? 24'hFFFFFF : 0 -> 64 sclk pulses, colour outputs alternating 0/1 starting at 0, ram_addr 320..383, line_done at cycle 129 after begin.
REQ-030 line_pwm=2 with RAM word 24'h444444 for all columns -> all six colour outputs 1 on every column; line_pwm=3 with the same data -> all 0.
REQ-031 Field mapping with RAM word 24'h000001 and line_pwm=0 -> only r0=1; with 24'h100000 -> only b1=1.
REQ-032 Second line_begin pulsed at cycle 40 of an active line -> ignored, row unchanged, exactly one line_done.
REQ-033 rst_n low at cycle 60 -> all outputs 0 immediately, no line_done; a new line_begin after release completes normally.
REQ-034 line_begin held high continuously -> back-to-back lines of 130 cycles each, each with exactly one line_done and 64 sclk pulses.
